// File: rtl/pps_monitor.sv
// PPS receive monitor: qualifies pps_in, measures edge-to-edge period, flags missing pulses, tracks lock.
// Optional glitch filter on the synchronized input is enabled by defining PPS_MON_FILTER_EN.
module pps_monitor #(
  parameter int unsigned NOMINAL_PERIOD = 100000,
  parameter int unsigned TOLERANCE      = 100,
  parameter int unsigned LOCK_COUNT     = 4,
  parameter int unsigned MISS_LIMIT     = 3,
  parameter int unsigned FILTER_CYCLES  = 4
) (
  input  logic        clk_pps,
  input  logic        reset_pps_n,
  input  logic        pps_in,
  output logic [31:0] period,
  output logic [31:0] period_error,
  output logic        period_valid,
  output logic        in_window,
  output logic        missing_pulse,
  output logic [7:0]  miss_count,
  output logic [1:0]  lock_state,
  output logic        locked
);

  localparam logic [31:0] NOM        = 32'(NOMINAL_PERIOD);
  localparam logic [31:0] TIMEOUT_AT = 32'(NOMINAL_PERIOD + TOLERANCE);
  localparam logic [31:0] RELOAD     = 32'(TOLERANCE + 1);
  localparam logic [32:0] WIN_HI     = {1'b0, TIMEOUT_AT};
  localparam logic [32:0] WIN_LO     = (NOMINAL_PERIOD > TOLERANCE) ?
                                       33'(NOMINAL_PERIOD - TOLERANCE) : 33'd0;

  typedef enum logic [1:0] {
    UNLOCKED = 2'b00,
    ACQUIRE  = 2'b01,
    LOCKED   = 2'b10,
    HOLDOVER = 2'b11
  } lock_t;

  logic sync1, sync2, lvl_d;
  logic pps_lvl;

  always_ff @(posedge clk_pps or negedge reset_pps_n) begin
    if (!reset_pps_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      lvl_d <= 1'b0;
    end else begin
      sync1 <= pps_in;
      sync2 <= sync1;
      lvl_d <= pps_lvl;
    end
  end

`ifdef PPS_MON_FILTER_EN
  localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  logic [FW-1:0] flt_cnt;
  logic          flt_lvl;

  // Level follows sync2 only after FILTER_CYCLES consecutive differing samples.
  always_ff @(posedge clk_pps or negedge reset_pps_n) begin
    if (!reset_pps_n) begin
      flt_cnt <= '0;
      flt_lvl <= 1'b0;
    end else if (sync2 == flt_lvl) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FW'(FILTER_CYCLES - 1)) begin
      flt_lvl <= sync2;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  assign pps_lvl = flt_lvl;
`else
  assign pps_lvl = sync2;
  // FILTER_CYCLES has no effect without the filter.
  if (FILTER_CYCLES == 0) begin : g_filter_unused
  end
`endif

  logic        edge_det;
  logic        meas_ok;
  logic        timeout;
  logic        win_ok;
  logic [32:0] cyc_ext;
  logic [31:0] cyc_ctr;
  logic        have_ref;
  logic [7:0]  miss_inc;

  assign edge_det = pps_lvl & ~lvl_d;
  assign meas_ok  = edge_det & have_ref;
  assign timeout  = have_ref & (cyc_ctr == TIMEOUT_AT) & ~edge_det;
  assign cyc_ext  = {1'b0, cyc_ctr};
  assign win_ok   = (cyc_ext >= WIN_LO) && (cyc_ext <= WIN_HI);
  assign miss_inc = (miss_count == 8'hFF) ? 8'hFF : miss_count + 8'd1;

  always_ff @(posedge clk_pps or negedge reset_pps_n) begin
    if (!reset_pps_n) begin
      cyc_ctr       <= '0;
      have_ref      <= 1'b0;
      period        <= '0;
      period_error  <= '0;
      period_valid  <= 1'b0;
      in_window     <= 1'b0;
      missing_pulse <= 1'b0;
      miss_count    <= '0;
    end else begin
      period_valid  <= meas_ok;
      missing_pulse <= timeout;
      if (edge_det) begin
        cyc_ctr    <= 32'd1;
        have_ref   <= 1'b1;
        miss_count <= '0;
        if (have_ref) begin
          period       <= cyc_ctr;
          // Low 32 bits of the 33-bit difference are the two's-complement error.
          period_error <= cyc_ctr - NOM;
          in_window    <= win_ok;
        end
      end else if (timeout) begin
        // Restart as if an edge had arrived at the nominal time.
        cyc_ctr    <= RELOAD;
        miss_count <= miss_inc;
      end else if (cyc_ctr != 32'hFFFF_FFFF) begin
        cyc_ctr <= cyc_ctr + 32'd1;
      end
    end
  end

  lock_t       state_reg, state_next;
  logic [31:0] good_reg, good_next;

  always_ff @(posedge clk_pps or negedge reset_pps_n) begin
    if (!reset_pps_n) begin
      state_reg <= UNLOCKED;
      good_reg  <= '0;
    end else begin
      state_reg <= state_next;
      good_reg  <= good_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    good_next  = good_reg;
    if (meas_ok) begin
      case (state_reg)
        UNLOCKED: begin
          if (win_ok) begin
            good_next  = 32'd1;
            state_next = (LOCK_COUNT <= 1) ? LOCKED : ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (win_ok) begin
            good_next = good_reg + 32'd1;
            if (good_reg + 32'd1 >= 32'(LOCK_COUNT)) state_next = LOCKED;
          end else begin
            good_next  = '0;
            state_next = UNLOCKED;
          end
        end
        LOCKED: begin
          if (!win_ok) begin
            good_next  = '0;
            state_next = UNLOCKED;
          end
        end
        HOLDOVER: begin
          if (win_ok) begin
            state_next = LOCKED;
          end else begin
            good_next  = '0;
            state_next = UNLOCKED;
          end
        end
        default: state_next = UNLOCKED;
      endcase
    end else if (timeout) begin
      case (state_reg)
        UNLOCKED: state_next = UNLOCKED;
        ACQUIRE: begin
          good_next  = '0;
          state_next = UNLOCKED;
        end
        LOCKED:   state_next = HOLDOVER;
        HOLDOVER: begin
          if ({24'd0, miss_inc} >= 32'(MISS_LIMIT)) begin
            good_next  = '0;
            state_next = UNLOCKED;
          end
        end
        default: state_next = UNLOCKED;
      endcase
    end
  end

  assign lock_state = state_reg;
  assign locked     = (state_reg == LOCKED) || (state_reg == HOLDOVER);

endmodule

// File: tb/tb_pps_monitor.sv
// Bench for pps_monitor: table of edge gaps / expected misses feeding a scoreboard, plus glitch and reset sequences.
module tb_pps_monitor;
  localparam int NP = 1000;
  localparam int TOL = 10;
  localparam int LC = 3;
  localparam int ML = 2;
  localparam int FC = 4;
  localparam int PW = 20;
`ifdef PPS_MON_FILTER_EN
  localparam int LAT = 3 + FC;
`else
  localparam int LAT = 3;
`endif
  localparam int NV = 24;

  logic        clk_pps = 1'b0;
  logic        reset_pps_n;
  logic        pps_in;
  logic [31:0] period;
  logic [31:0] period_error;
  logic        period_valid;
  logic        in_window;
  logic        missing_pulse;
  logic [7:0]  miss_count;
  logic [1:0]  lock_state;
  logic        locked;

  pps_monitor #(
    .NOMINAL_PERIOD(NP),
    .TOLERANCE(TOL),
    .LOCK_COUNT(LC),
    .MISS_LIMIT(ML),
    .FILTER_CYCLES(FC)
  ) dut (
    .clk_pps(clk_pps),
    .reset_pps_n(reset_pps_n),
    .pps_in(pps_in),
    .period(period),
    .period_error(period_error),
    .period_valid(period_valid),
    .in_window(in_window),
    .missing_pulse(missing_pulse),
    .miss_count(miss_count),
    .lock_state(lock_state),
    .locked(locked)
  );

  always #5 clk_pps = ~clk_pps;

  int cyc = 0;
  always @(posedge clk_pps) cyc <= cyc + 1;

  // kind 0 = period strobe, 1 = missing pulse; t = gap (table) or strobe cycle (scoreboard)
  typedef struct {
    int          kind;
    int          t;
    logic [31:0] period;
    logic [31:0] err;
    logic        inw;
    logic [1:0]  lock;
    logic [7:0]  mcnt;
  } rec_t;

  rec_t sb[$];
  rec_t tbl[NV];
  int   tests = 0;
  int   fails = 0;
  int   n_valid = 0;
  int   last_rise = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk_pps) begin : mon
    rec_t e;
    if (period_valid) n_valid++;
    if (period_valid || missing_pulse) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: valid=%0b miss=%0b at cycle %0d, required none",
                 period_valid, missing_pulse, cyc);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", 32'(missing_pulse), 32'(e.kind));
        check("strobe_cycle", 32'(cyc), 32'(e.t));
        if (e.kind == 0) begin
          check("period", period, e.period);
          check("period_error", period_error, e.err);
          check("in_window", 32'(in_window), 32'(e.inw));
        end
        check("lock_state", 32'(lock_state), 32'(e.lock));
        check("locked", 32'(locked), 32'(e.lock[1]));
        check("miss_count", 32'(miss_count), 32'(e.mcnt));
        $display("[TB] cycle %0d %s period=%0d err=%0d win=%0b state=%0d miss_count=%0d",
                 cyc, missing_pulse ? "miss " : "valid", period, $signed(period_error),
                 in_window, lock_state, miss_count);
      end
    end
  end

  task automatic tick();
    @(negedge clk_pps);
    if (pps_in && (cyc - last_rise) >= PW) pps_in = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic rise();
    pps_in    = 1'b1;
    last_rise = cyc;
  endtask

  task automatic push_edge(input logic [31:0] p, input logic [31:0] er, input logic w,
                           input logic [1:0] ls);
    rec_t r;
    r = '{0, cyc + LAT, p, er, w, ls, 8'd0};
    sb.push_back(r);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, period, 32'd0);
    check({tag, "_error"}, period_error, 32'd0);
    check({tag, "_valid"}, 32'(period_valid), 32'd0);
    check({tag, "_in_window"}, 32'(in_window), 32'd0);
    check({tag, "_missing"}, 32'(missing_pulse), 32'd0);
    check({tag, "_miss_count"}, 32'(miss_count), 32'd0);
    check({tag, "_lock_state"}, 32'(lock_state), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
  endtask

  initial begin
    int   nv0;
    int   r0;
    int   g;
    rec_t r;

    tbl[0]  = '{0, 1000, 32'd1000, 32'd0,          1'b1, 2'b01, 8'd0};
    tbl[1]  = '{0, 1000, 32'd1000, 32'd0,          1'b1, 2'b01, 8'd0};
    tbl[2]  = '{0, 1000, 32'd1000, 32'd0,          1'b1, 2'b10, 8'd0};
    tbl[3]  = '{0, 1000, 32'd1000, 32'd0,          1'b1, 2'b10, 8'd0};
    tbl[4]  = '{1, 1010, 32'd0,    32'd0,          1'b0, 2'b11, 8'd1};
    tbl[5]  = '{0, 1015, 32'd15,   32'hFFFF_FC27,  1'b0, 2'b00, 8'd0};
    tbl[6]  = '{0, 1000, 32'd1000, 32'd0,          1'b1, 2'b01, 8'd0};
    tbl[7]  = '{0, 1000, 32'd1000, 32'd0,          1'b1, 2'b01, 8'd0};
    tbl[8]  = '{0, 1000, 32'd1000, 32'd0,          1'b1, 2'b10, 8'd0};
    tbl[9]  = '{0, 985,  32'd985,  32'hFFFF_FFF1,  1'b0, 2'b00, 8'd0};
    tbl[10] = '{0, 1000, 32'd1000, 32'd0,          1'b1, 2'b01, 8'd0};
    tbl[11] = '{0, 1000, 32'd1000, 32'd0,          1'b1, 2'b01, 8'd0};
    tbl[12] = '{0, 1000, 32'd1000, 32'd0,          1'b1, 2'b10, 8'd0};
    tbl[13] = '{0, 1010, 32'd1010, 32'd10,         1'b1, 2'b10, 8'd0};
    tbl[14] = '{0, 990,  32'd990,  32'hFFFF_FFF6,  1'b1, 2'b10, 8'd0};
    tbl[15] = '{0, 989,  32'd989,  32'hFFFF_FFF5,  1'b0, 2'b00, 8'd0};
    tbl[16] = '{0, 1000, 32'd1000, 32'd0,          1'b1, 2'b01, 8'd0};
    tbl[17] = '{0, 1000, 32'd1000, 32'd0,          1'b1, 2'b01, 8'd0};
    tbl[18] = '{0, 1000, 32'd1000, 32'd0,          1'b1, 2'b10, 8'd0};
    tbl[19] = '{1, 1010, 32'd0,    32'd0,          1'b0, 2'b11, 8'd1};
    tbl[20] = '{0, 2000, 32'd1000, 32'd0,          1'b1, 2'b10, 8'd0};
    tbl[21] = '{1, 1010, 32'd0,    32'd0,          1'b0, 2'b11, 8'd1};
    tbl[22] = '{1, 2010, 32'd0,    32'd0,          1'b0, 2'b00, 8'd2};
    tbl[23] = '{0, 3000, 32'd1000, 32'd0,          1'b1, 2'b01, 8'd0};

    // Reset with pps_in toggling, then a reference-only first edge
    reset_pps_n = 1'b0;
    pps_in      = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_pps);
      pps_in = ~pps_in;
    end
    pps_in = 1'b0;
    #1;
    check_zero("reset");
    @(negedge clk_pps);
    reset_pps_n = 1'b1;
    repeat (50) tick();
    rise();
    repeat (30) tick();
    check("first_edge_no_valid", 32'(n_valid), 32'd0);

    for (int i = 0; i < NV; i++) begin
      r = tbl[i];
      if (r.kind == 1) begin
        r.t = last_rise + LAT + r.t;
        sb.push_back(r);
      end else begin
        wait_until(last_rise + r.t);
        rise();
        push_edge(r.period, r.err, r.inw, r.lock);
      end
    end

    // 2-cycle glitch 500 cycles after an edge (state is ACQUIRE here)
    r0 = last_rise;
    wait_until(r0 + 500);
    g = cyc;
    pps_in = 1'b1;
    @(negedge clk_pps);
    @(negedge clk_pps);
    pps_in = 1'b0;
`ifndef PPS_MON_FILTER_EN
    r = '{0, g + LAT, 32'd500, 32'hFFFF_FE0C, 1'b0, 2'b00, 8'd0};
    sb.push_back(r);
`endif
    wait_until(r0 + 1000);
    rise();
`ifdef PPS_MON_FILTER_EN
    push_edge(32'd1000, 32'd0, 1'b1, 2'b01);
`else
    push_edge(32'd500, 32'hFFFF_FE0C, 1'b0, 2'b00);
`endif

    // Reset 600 cycles into a period: outputs clear and the reference is lost
    wait_until(last_rise + 600);
    reset_pps_n = 1'b0;
    #1;
    check_zero("mid_reset");
    repeat (5) tick();
    reset_pps_n = 1'b1;
    nv0 = n_valid;
    repeat (100) tick();
    rise();
    repeat (30) tick();
    check("no_valid_after_reset", 32'(n_valid), 32'(nv0));
    wait_until(last_rise + 1000);
    rise();
    push_edge(32'd1000, 32'd0, 1'b1, 2'b01);
    repeat (60) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
